// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand-forwarding selects and stall/flush control for the five-stage core.
// Tracks in-flight destinations in an E/M/W shadow pipeline; includes MDU occupancy with timeout.
`default_nettype none

module hazard_ctrl #(
   parameter int MDU_MAX_CYCLES = 34,
   parameter int CNT_W          = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] rs1_d,
   input  logic [4:0] rs2_d,
   input  logic [4:0] rd_d,
   input  logic       regwrite_d,
   input  logic       load_d,
   input  logic       mdu_d,
   input  logic       pcsrc_e,
   input  logic       mdu_done,
   output logic [1:0] forward_a_e,
   output logic [1:0] forward_b_e,
   output logic       stall_f,
   output logic       stall_d,
   output logic       stall_e,
   output logic       flush_d,
   output logic       flush_e,
   output logic       flush_m,
   output logic       mdu_timeout
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MDU_MAX_CYCLES);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic [4:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       regwrite_e, load_e, mdu_e, regwrite_m, regwrite_w;

   logic lw_stall, mdu_stall, pc_take;

   // M stage is younger than W, so its result takes precedence.
   always_comb begin
      forward_a_e = 2'b00;
      if (regwrite_m && rd_m != 5'd0 && rd_m == rs1_e)
         forward_a_e = 2'b10;
      else if (regwrite_w && rd_w != 5'd0 && rd_w == rs1_e)
         forward_a_e = 2'b01;
   end

   always_comb begin
      forward_b_e = 2'b00;
      if (regwrite_m && rd_m != 5'd0 && rd_m == rs2_e)
         forward_b_e = 2'b10;
      else if (regwrite_w && rd_w != 5'd0 && rd_w == rs2_e)
         forward_b_e = 2'b01;
   end

   assign lw_stall    = load_e && (rd_e != 5'd0) && (rd_e == rs1_d || rd_e == rs2_d) && !pcsrc_e;
   assign mdu_stall   = mdu_e && !mdu_done && (cnt < MAX_C);
   assign mdu_timeout = mdu_e && !mdu_done && (state == WAIT) && (cnt == MAX_C);

   // A branch cannot be resolving while an MDU op holds E; gated by rst_n so
   // every output reads zero during reset.
   assign pc_take = pcsrc_e && !mdu_stall && rst_n;

   assign stall_f = lw_stall | mdu_stall;
   assign stall_d = lw_stall | mdu_stall;
   assign stall_e = mdu_stall;
   assign flush_m = mdu_stall;
   assign flush_d = pc_take;
   assign flush_e = pc_take | lw_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_e      <= 5'd0;
         rs2_e      <= 5'd0;
         rd_e       <= 5'd0;
         regwrite_e <= 1'b0;
         load_e     <= 1'b0;
         mdu_e      <= 1'b0;
         rd_m       <= 5'd0;
         regwrite_m <= 1'b0;
         rd_w       <= 5'd0;
         regwrite_w <= 1'b0;
      end else begin
         rd_w       <= rd_m;
         regwrite_w <= regwrite_m;
         if (mdu_stall) begin
            rd_m       <= 5'd0;
            regwrite_m <= 1'b0;
         end else begin
            rd_m       <= rd_e;
            regwrite_m <= regwrite_e;
            if (flush_e) begin
               rs1_e      <= 5'd0;
               rs2_e      <= 5'd0;
               rd_e       <= 5'd0;
               regwrite_e <= 1'b0;
               load_e     <= 1'b0;
               mdu_e      <= 1'b0;
            end else begin
               rs1_e      <= rs1_d;
               rs2_e      <= rs2_d;
               rd_e       <= rd_d;
               regwrite_e <= regwrite_d;
               load_e     <= load_d;
               mdu_e      <= mdu_d;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mdu_stall) begin
                  state <= WAIT;
                  cnt   <= CNT_W'(1);
               end else begin
                  cnt <= '0;
               end
            end
            WAIT: begin
               if (mdu_stall) begin
                  cnt <= cnt + CNT_W'(1);
               end else begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed literal checks plus randomized traffic compared every
// cycle against a stage-record reference model.
`default_nettype none

module tb_hazard_ctrl;

   localparam int MAXC = 34;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] rs1_d, rs2_d, rd_d;
   logic       regwrite_d, load_d, mdu_d, pcsrc_e, mdu_done;
   logic [1:0] forward_a_e, forward_b_e;
   logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_timeout;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.MDU_MAX_CYCLES(MAXC), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .regwrite_d(regwrite_d), .load_d(load_d), .mdu_d(mdu_d),
      .pcsrc_e(pcsrc_e), .mdu_done(mdu_done),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
      .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
      .mdu_timeout(mdu_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- reference model: one record per occupied stage ----------------
   typedef struct packed {
      logic [4:0] rs1, rs2, rd;
      logic       rw, ld, mdu;
   } ent_t;

   ent_t me, mm, mw, ne, nm, nw;
   int   mstall, nstall;   // consecutive stall cycles spent by the op now in E

   function automatic logic [1:0] fwd_of(input logic [4:0] s);
      if (mm.rw && mm.rd != 0 && mm.rd == s) return 2'b10;
      if (mw.rw && mw.rd != 0 && mw.rd == s) return 2'b01;
      return 2'b00;
   endfunction

   always @(negedge clk) begin : compare
      ent_t d;
      logic lw, ms, tmo, pc;
      if (rst_n) begin
         d   = {rs1_d, rs2_d, rd_d, regwrite_d, load_d, mdu_d};
         lw  = me.ld && me.rd != 0 && (me.rd == rs1_d || me.rd == rs2_d) && !pcsrc_e;
         ms  = me.mdu && !mdu_done && (mstall < MAXC);
         tmo = me.mdu && !mdu_done && (mstall == MAXC);
         pc  = pcsrc_e && !ms;
         check("m_fwd_a",   forward_a_e, fwd_of(me.rs1));
         check("m_fwd_b",   forward_b_e, fwd_of(me.rs2));
         check("m_stall_f", stall_f, lw | ms);
         check("m_stall_d", stall_d, lw | ms);
         check("m_stall_e", stall_e, ms);
         check("m_flush_m", flush_m, ms);
         check("m_flush_d", flush_d, pc);
         check("m_flush_e", flush_e, pc | lw);
         check("m_timeout", mdu_timeout, tmo);
         nw = mm;
         if (ms) begin
            ne = me; nm = '0; nstall = mstall + 1;
         end else begin
            nm = me; ne = (pc | lw) ? '0 : d; nstall = 0;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         me <= '0; mm <= '0; mw <= '0; mstall <= 0;
      end else begin
         me <= ne; mm <= nm; mw <= nw; mstall <= nstall;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic rw, input logic ld, input logic md);
      rs1_d = a; rs2_d = b; rd_d = d; regwrite_d = rw; load_d = ld; mdu_d = md;
   endtask

   function automatic logic [12:0] outs();
      return {forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
              flush_d, flush_e, flush_m, mdu_timeout};
   endfunction

   task automatic randomize_inputs();
      int r;
      setd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 7, 1'b0, 1'b0);
      r = $urandom_range(0, 19);
      load_d   = (r < 4);
      mdu_d    = (r == 4);
      pcsrc_e  = ($urandom_range(0, 9) == 0);
      mdu_done = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; pcsrc_e = 1'b0; mdu_done = 1'b0;
      setd(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("reset_outs", 32'(outs()), 32'd0);

      // forwarding: add x5, dependent next cycle (M) and two cycles later (W)
      setd(0, 0, 5, 1, 0, 0); tick();
      setd(5, 1, 6, 1, 0, 0); tick();
      #1 check("fwd_m", 32'(forward_a_e), 32'd2);
      setd(5, 0, 0, 0, 0, 0); tick();
      #1 check("fwd_w", 32'(forward_a_e), 32'd1);
      setd(0, 0, 0, 1, 0, 0); tick();
      setd(0, 0, 0, 0, 0, 0); tick();
      #1 check("fwd_x0", 32'(forward_a_e), 32'd0);

      // load-use: lw x7 ; add x8,x7,x1
      setd(0, 0, 7, 1, 1, 0); tick();
      setd(7, 1, 8, 1, 0, 0);
      #1 check("lu_stall", 32'({stall_f, stall_d, flush_e, flush_d}), 32'b1110);
      tick();
      #1 check("lu_release", 32'({stall_f, stall_d, flush_e}), 32'b000);
      tick();
      #1 check("lu_fwd_w", 32'(forward_a_e), 32'd1);

      // load in E with taken branch: no interlock, just squash
      setd(0, 0, 7, 1, 1, 0); tick();
      setd(7, 0, 8, 1, 0, 0); pcsrc_e = 1'b1;
      #1 check("br_lw", 32'({flush_d, flush_e, stall_f, stall_d}), 32'b1100);
      tick(); pcsrc_e = 1'b0;

      // MDU op finishing after 5 cycles, then a back-to-back op that times out
      setd(0, 0, 9, 1, 0, 1); tick();
      setd(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         #1 check("mdu5_stall", 32'({stall_e, flush_m, mdu_timeout}), 32'b110);
         tick();
      end
      mdu_done = 1'b1; setd(0, 0, 10, 1, 0, 1);
      #1 check("mdu5_done", 32'({stall_e, mdu_timeout}), 32'b00);
      tick(); mdu_done = 1'b0; setd(0, 0, 0, 0, 0, 0);
      n = 0;
      while (n < 60) begin
         #1;
         if (!stall_e) break;
         n++;
         tick();
      end
      check("mdu_to_cycles", 32'(n), 32'(MAXC));
      check("mdu_to_pulse", 32'(mdu_timeout), 32'd1);
      tick();
      #1 check("mdu_to_once", 32'(mdu_timeout), 32'd0);

      // asynchronous reset in the middle of an MDU wait
      setd(0, 0, 9, 1, 0, 1); tick();
      setd(0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      pcsrc_e = 1'b1; rst_n = 1'b0;
      #1 check("rst_mid_outs", 32'(outs()), 32'd0);
      tick();
      check("rst_hold_outs", 32'(outs()), 32'd0);
      pcsrc_e = 1'b0; rst_n = 1'b1;
      setd(9, 9, 1, 1, 0, 0);
      #1 check("rst_post_stall", 32'({stall_f, stall_e, flush_e}), 32'b000);
      tick();
      #1 check("rst_post_fwd", 32'({forward_a_e, forward_b_e}), 32'd0);

      // randomized traffic, compared each cycle by the model
      for (int i = 0; i < 4000; i++) begin
         tick();
         if (i == 2000) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         randomize_inputs();
      end
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage pipelined core. Tracks destination registers of in-flight instructions in an internal shadow pipeline (E/M/W) and drives the 2-bit select inputs of the E-stage operand forwarding 3-input muxes. Also generates stall/flush controls for the F/D/E/M pipeline registers: load-use interlock, taken-branch squash, and multi-cycle MDU (mul/div) occupancy with a timeout.

## Interface
- MDU_MAX_CYCLES, 34, max stall cycles per MDU op before forced release
- CNT_W, 6, width of MDU stall counter; must hold MDU_MAX_CYCLES
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs1_d, rs2_d  in  5  D-stage source register indices
- rd_d  in  5  D-stage destination index
- regwrite_d  in  1  D-stage instruction writes rd
- load_d  in  1  D-stage instruction is a load (result comes from memory)
- mdu_d  in  1  D-stage instruction is an MDU op
- pcsrc_e  in  1  branch/jump taken, resolved in E
- mdu_done  in  1  MDU result valid this cycle
- forward_a_e, forward_b_e  out  2  mux select: 00 regfile, 01 W result, 10 M ALU result
- stall_f, stall_d, stall_e  out  1  hold PC / D / E pipeline register
- flush_d, flush_e, flush_m  out  1  load bubble into D / E / M register
- mdu_timeout  out  1  one-cycle pulse when MDU stall was force-released

## Operation
- Shadow state: E {rs1, rs2, rd, regwrite, load, mdu}; M {rd, regwrite}; W {rd, regwrite}. Reset clears all; regwrite/load/mdu = 0.
- Forward A (B same with rs2_e): 10 if regwrite_m && rd_m != 0 && rd_m == rs1_e; else 01 if regwrite_w && rd_w != 0 && rd_w == rs1_e; else 00. M beats W. Encoding 11 never driven.
- lw_stall = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d) && !pcsrc_e.
- mdu_stall = mdu_e && !mdu_done && state == WAIT-eligible (cnt < MDU_MAX_CYCLES).
- Outputs: stall_f = stall_d = lw_stall | mdu_stall; stall_e = flush_m = mdu_stall; flush_d = pcsrc_e; flush_e = pcsrc_e | lw_stall.
- pcsrc_e has priority over lw_stall (D is wrong-path). pcsrc_e cannot coincide with mdu_e (branch and MDU op both occupy E); if asserted together, mdu_stall wins and pcsrc_e is ignored.
- Shadow advance per edge: W <= M always. If mdu_stall: E holds, M <= bubble. Else M <= E; E <= bubble if flush_e else D-stage inputs.
- MDU FSM: IDLE -> WAIT when mdu_e && !mdu_done (first stall cycle), cnt <= 1. WAIT: cnt++ each stalled cycle; -> IDLE on mdu_done, or when cnt == MDU_MAX_CYCLES (then mdu_stall drops, mdu_timeout = 1 that cycle, E advances). Counter clears in IDLE.
- Back-to-back MDU ops: second enters E after first releases; FSM re-enters WAIT from IDLE without gap.

## Timing
- Forward selects: combinational from registered shadow state; valid same cycle the consumer is in E.
- Stall/flush: combinational from shadow state and same-cycle D/E inputs; act on the next edge.
- Load-use: exactly one stall cycle; the dependent op then sees forward = 01 in E.
- MDU op with mdu_done in its first E cycle: zero stall cycles. With done after k cycles: k stall cycles (k < MDU_MAX_CYCLES).
- Reset (async, any time incl. mid-MDU stall): shadow cleared, FSM IDLE, cnt 0; while rst_n low all outputs 0 and forwards 00. First post-reset cycle: no stalls unless inputs demand.

## Test plan
- add x5 in D, then sub using x5 one cycle later -> forward_a_e = 10; two cycles later -> 01; rd = x0 -> 00.
- lw x7 then add x8,x7,x1 -> one cycle stall_f = stall_d = flush_e = 1, then forward_a_e = 01.
- lw x7 in E, pcsrc_e = 1, dependent in D -> flush_d = flush_e = 1, stall_f = stall_d = 0.
- MDU op, mdu_done after 5 cycles -> stall_e = flush_m = 1 for exactly 5 cycles, mdu_timeout = 0.
- MDU op, mdu_done never -> release after MDU_MAX_CYCLES (34) stall cycles, mdu_timeout pulses once.
- rst_n low during MDU WAIT at cycle 3 -> all outputs 0 immediately; after release, FSM IDLE, no forwarding from pre-reset ops.
